// File: rtl/cmp_arbiter_if.sv
// Handshake bundle between the requester side (master) and cmp_arbiter (slave),
// including the operand/result path to the shared comparator.
interface cmp_arbiter_if #(
   parameter int NREQ = 4,
   parameter int W    = 4
);
   logic [NREQ-1:0]   req;
   logic [NREQ*W-1:0] inp_bus;
   logic [NREQ*W-1:0] test_bus;
   logic [W-1:0]      cmp_inp;
   logic [W-1:0]      cmp_test;
   logic [W-1:0]      cmp_outp;
   logic [NREQ-1:0]   gnt;
   logic [NREQ-1:0]   done;
   logic [W-1:0]      result;
   logic              busy;

   modport master (
      output req, inp_bus, test_bus, cmp_outp,
      input  cmp_inp, cmp_test, gnt, done, result, busy
   );

   modport slave (
      input  req, inp_bus, test_bus, cmp_outp,
      output cmp_inp, cmp_test, gnt, done, result, busy
   );
endinterface

// File: rtl/cmp_arbiter.sv
// Round-robin arbiter time-sharing one W-bit comparator among NREQ requesters;
// one transaction every four cycles.
//
//   state | meaning
//   IDLE  | waiting for any req; picks winner, drives inp and complemented test
//   GNT   | drives true test operand so the comparator always sees an edge
//   CAP   | captures comparator result, pulses done, advances pointer
//   RSP   | done visible to requester; req ignored; clears gnt/done
module cmp_arbiter #(
   parameter int NREQ = 4,
   parameter int W    = 4
) (
   input  logic         clk,
   input  logic         rst,
   cmp_arbiter_if.slave arb
);
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE, GNT, CAP, RSP} state_t;

   state_t          state;
   logic [IW-1:0]   ptr;
   logic [IW-1:0]   gsel;
   logic [IW-1:0]   win;
   logic [IW-1:0]   idx;
   logic            found;
   logic [NREQ-1:0] gnt_r;
   logic [NREQ-1:0] done_r;
   logic [W-1:0]    inp_r;
   logic [W-1:0]    test_r;
   logic [W-1:0]    result_r;

   // First requester at or above ptr, wrapping back to 0.
   always_comb begin
      win   = ptr;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = IW'((int'(ptr) + k) % NREQ);
         if (!found && arb.req[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         ptr      <= '0;
         gsel     <= '0;
         gnt_r    <= '0;
         done_r   <= '0;
         inp_r    <= '0;
         test_r   <= '0;
         result_r <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|arb.req) begin
                  gsel   <= win;
                  gnt_r  <= NREQ'(1) << win;
                  inp_r  <= arb.inp_bus[W*win +: W];
                  test_r <= ~arb.test_bus[W*win +: W];
                  state  <= GNT;
               end
            end
            GNT: begin
               test_r <= arb.test_bus[W*gsel +: W];
               state  <= CAP;
            end
            CAP: begin
               result_r <= arb.cmp_outp;
               done_r   <= NREQ'(1) << gsel;
               ptr      <= (gsel == IW'(NREQ - 1)) ? '0 : gsel + IW'(1);
               state    <= RSP;
            end
            RSP: begin
               done_r <= '0;
               gnt_r  <= '0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign arb.gnt      = gnt_r;
   assign arb.done     = done_r;
   assign arb.cmp_inp  = inp_r;
   assign arb.cmp_test = test_r;
   assign arb.result   = result_r;
   assign arb.busy     = (state != IDLE);
endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed and randomized transactions on cmp_arbiter, checked against a
// transaction-level model of round-robin order and the comparator rule.
module tb_cmp_arbiter;
   localparam int NREQ = 4;
   localparam int W    = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cmp_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

   cmp_arbiter #(.NREQ(NREQ), .W(W)) dut (
      .clk (clk),
      .rst (rst),
      .arb (bus)
   );

   // Shared comparator: passes test through when test <= inp, else zero.
   assign bus.cmp_outp = (bus.cmp_test <= bus.cmp_inp) ? bus.cmp_test : '0;

   int checks   = 0;
   int failures = 0;
   int mptr     = 0;
   logic [W-1:0] inp_v  [NREQ];
   logic [W-1:0] test_v [NREQ];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive();
      for (int i = 0; i < NREQ; i++) begin
         bus.inp_bus[W*i +: W]  = inp_v[i];
         bus.test_bus[W*i +: W] = test_v[i];
      end
   endtask

   function automatic int pick(input logic [NREQ-1:0] mask, input int p);
      for (int k = 0; k < NREQ; k++)
         if (mask[(p + k) % NREQ]) return (p + k) % NREQ;
      return -1;
   endfunction

   // One full transaction starting from IDLE; late >= 0 rewrites the winner's
   // test operand (and drops req) after the GNT edge.
   task automatic txn(input logic [NREQ-1:0] mask, input int late);
      int g;
      logic [W-1:0] ei, et, er, nt;
      bus.req = mask;
      drive();
      g  = pick(mask, mptr);
      ei = inp_v[g];
      et = test_v[g];
      nt = ~et;
      er = (et <= ei) ? et : '0;
      step();
      chk("gnt_e0", bus.gnt, 32'(1) << g);
      chk("busy_e0", bus.busy, 1);
      chk("done_e0", bus.done, 0);
      chk("cmp_inp_e0", bus.cmp_inp, ei);
      chk("cmp_test_inv_e0", bus.cmp_test, nt);
      step();
      chk("gnt_e1", bus.gnt, 32'(1) << g);
      chk("cmp_test_e1", bus.cmp_test, et);
      if (late >= 0) begin
         test_v[g] = W'(late);
         bus.req   = '0;
         drive();
      end
      step();
      chk("gnt_e2", bus.gnt, 32'(1) << g);
      chk("done_e2", bus.done, 32'(1) << g);
      chk("result_e2", bus.result, er);
      chk("busy_e2", bus.busy, 1);
      bus.req = mask & ~(NREQ'(1) << g);
      step();
      chk("done_e3", bus.done, 0);
      chk("gnt_e3", bus.gnt, 0);
      chk("busy_e3", bus.busy, 0);
      chk("result_hold", bus.result, er);
      chk("cmp_inp_hold", bus.cmp_inp, ei);
      chk("cmp_test_hold", bus.cmp_test, et);
      mptr = (g + 1) % NREQ;
   endtask

   initial begin
      rst = 1'b1;
      bus.req = '0;
      for (int i = 0; i < NREQ; i++) begin
         inp_v[i]  = '0;
         test_v[i] = '0;
      end
      drive();
      step();
      step();
      chk("rst_gnt", bus.gnt, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_result", bus.result, 0);
      chk("rst_cmp_inp", bus.cmp_inp, 0);
      chk("rst_cmp_test", bus.cmp_test, 0);
      chk("rst_busy", bus.busy, 0);
      rst = 1'b0;

      // Single pass case and fail case
      inp_v[2] = 4'd9; test_v[2] = 4'd5;
      txn(4'b0100, -1);
      inp_v[0] = 4'd3; test_v[0] = 4'd12;
      txn(4'b0001, -1);

      // Same test operand twice must re-evaluate
      inp_v[1] = 4'd9; test_v[1] = 4'd7;
      txn(4'b0010, -1);
      inp_v[1] = 4'd2;
      txn(4'b0010, -1);

      // Bring pointer to 0, then full contention: order 0,1,2,3,0
      inp_v[3] = 4'd15; test_v[3] = 4'd1;
      txn(4'b1000, -1);
      for (int i = 0; i < NREQ; i++) begin
         inp_v[i]  = W'(4 + 3 * i);
         test_v[i] = W'(2 + 4 * i);
      end
      for (int n = 0; n < 5; n++) txn(4'b1111, -1);

      // Late operand change and req drop after grant
      inp_v[0] = 4'd9; test_v[0] = 4'd5;
      txn(4'b0001, 15);

      // Reset at the CAP edge of requester 3, with pointer parked at 2
      txn(4'b0010, -1);
      inp_v[3] = 4'd10; test_v[3] = 4'd4;
      drive();
      bus.req = 4'b1000;
      step();
      chk("mid_gnt_e0", bus.gnt, 4'b1000);
      step();
      rst = 1'b1;
      step();
      chk("mid_rst_gnt", bus.gnt, 0);
      chk("mid_rst_done", bus.done, 0);
      chk("mid_rst_result", bus.result, 0);
      chk("mid_rst_cmp_inp", bus.cmp_inp, 0);
      chk("mid_rst_cmp_test", bus.cmp_test, 0);
      chk("mid_rst_busy", bus.busy, 0);
      step();
      chk("rst_prio_gnt", bus.gnt, 0);
      chk("rst_prio_busy", bus.busy, 0);
      rst = 1'b0;
      mptr = 0;
      inp_v[1] = 4'd6; test_v[1] = 4'd6;
      inp_v[2] = 4'd1; test_v[2] = 4'd8;
      txn(4'b0110, -1);
      txn(4'b1000, -1);

      // Randomized traffic
      for (int n = 0; n < 40; n++) begin
         int late;
         for (int i = 0; i < NREQ; i++) begin
            inp_v[i]  = W'($urandom_range(0, 15));
            test_v[i] = W'($urandom_range(0, 15));
         end
         late = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1;
         txn(NREQ'($urandom_range(1, 15)), late);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
